logo_mover: RTL and testbench
=============================

LOGO_MOVER -- requirements
Module: logo_mover

Interface
REQ-001 Parameter H_RES, default 640: visible screen width in pixels.
REQ-002 Parameter V_RES, default 480: visible screen height in pixels.
REQ-003 Parameter WIDTH_LOGO, default 80: logo width in pixels.
REQ-004 Parameter HEIGHT_LOGO, default 96: logo height in pixels.
REQ-005 Parameter STEP, default 1: pixels moved per axis per frame; legal range 1..31.
REQ-006 Parameters X_INIT and Y_INIT, default 0: reset position; X_INIT SHALL be at most X_MAX, and Y_INIT SHALL be at most Y_MAX.
REQ-007 Port: clk  in  1  system clock; all state changes on its rising edge.
REQ-008 Port: clr  in  1  asynchronous, active-low reset.
REQ-009 Port: en  in  1  motion enable, level.
REQ-010 Port: vblank  in  1  vertical-blanking level from the sync generator, synchronous to clk.
REQ-011 Port: x_logo  out  10  logo top-left X, registered.
REQ-012 Port: y_logo  out  10  logo top-left Y, registered.
REQ-013 Port: dir_x  out  1  X direction, registered; 1 = moving right.
REQ-014 Port: dir_y  out  1  Y direction, registered; 1 = moving down.
REQ-015 Port: frame_done  out  1  one-cycle pulse marking a completed position update.
REQ-016 Port: bounce  out  1  one-cycle pulse, coincident with frame_done, when either axis reflected in that update.
REQ-017 Port: bounce_cnt  out  8  count of axis reflections.

Function
REQ-018 X_MAX SHALL equal H_RES-WIDTH_LOGO (560 at defaults), and Y_MAX SHALL equal V_RES-HEIGHT_LOGO (384 at defaults).
REQ-019 The FSM states SHALL be IDLE, WAIT, STEP_X, STEP_Y and DONE.
REQ-020 FSM transitions SHALL be:
- IDLE->WAIT when en=1.
- WAIT->STEP_X on a vblank rising edge (vblank=1 while its registered copy vblank_q=0).
- WAIT->IDLE when en=0.
- STEP_X->STEP_Y unconditionally.
- STEP_Y->DONE unconditionally.
- DONE->WAIT if en=1, else DONE->IDLE.
REQ-021 Latency: if cycle 0 is the cycle where the vblank rising edge is seen, then STEP_X occurs in cycle 1, the new x_logo is visible in cycle 2, the new y_logo is visible in cycle 3, and frame_done is high in cycle 3.
REQ-022 Positions SHALL change only on the STEP_X or STEP_Y exit edge, and SHALL hold in all other states.
REQ-023 X update with dir_x=1: if x_logo+STEP >= X_MAX, then x_logo<=X_MAX and dir_x<=0 (reflection); otherwise x_logo<=x_logo+STEP.
REQ-024 X update with dir_x=0: if x_logo <= STEP, then x_logo<=0 and dir_x<=1 (reflection); otherwise x_logo<=x_logo-STEP.
REQ-025 The Y update SHALL follow the same rules using y_logo, dir_y and Y_MAX.
REQ-026 Arithmetic SHALL use 11-bit intermediates; no wrap-around past 0 or past X_MAX/Y_MAX is permitted.
REQ-027 Landing exactly on a limit SHALL count as a reflection.
REQ-028 bounce SHALL be asserted in DONE if either axis reflected in that update; a corner hit (both axes reflect) SHALL produce a single bounce pulse.
REQ-029 A vblank rising edge seen outside WAIT SHALL be ignored, and at most one update SHALL occur per vblank period.
REQ-030 en deasserted during STEP_X, STEP_Y or DONE SHALL NOT abort the update; the FSM SHALL then go to IDLE from DONE.
REQ-031 vblank held high when en rises SHALL NOT trigger an update until the next rising edge.

Reset
REQ-032 While clr=0, outputs SHALL be: x_logo=X_INIT, y_logo=Y_INIT, dir_x=1, dir_y=1, frame_done=0, bounce=0, bounce_cnt=0.
REQ-033 While clr=0, internal state SHALL be: FSM=IDLE, vblank_q=0.
REQ-034 Reset asserted mid-update SHALL take effect immediately, and any partial update SHALL be discarded.
REQ-035 On clr release the FSM SHALL start from IDLE; the first update requires a fresh vblank rising edge.

Configuration
REQ-036 Macro LOGO_BOUNCE_COUNT_EN SHALL control the reflection counter.
REQ-037 With LOGO_BOUNCE_COUNT_EN defined, bounce_cnt SHALL increment by 1 per reflecting axis (by 2 on a corner hit) and SHALL saturate at 255.
REQ-038 Without LOGO_BOUNCE_COUNT_EN, bounce_cnt SHALL be tied to 0 and no counter logic SHALL be synthesised.

Verification
REQ-039 Reset check: clr low then high, en=1, one vblank pulse -> cycle 2 x_logo=1, cycle 3 y_logo=1 with frame_done=1, bounce=0.
REQ-040 Right-edge reflection: X_INIT=559, dir_x=1, STEP=1, one vblank -> x_logo=560, dir_x=0, bounce=1; next vblank -> x_logo=559.
REQ-041 Corner hit: X_INIT=0, Y_INIT=0, both directions forced to decrement, STEP=4 -> x_logo=0, y_logo=0, dir_x=1, dir_y=1, a single bounce pulse, bounce_cnt=2 (macro on) or 0 (macro off).
REQ-042 Disable and stale edge: en=0 then 5 vblank pulses -> position unchanged; en=1 raised while vblank is high -> no update until the next rising edge.
REQ-043 Reset mid-update: clr pulsed low during STEP_Y -> x_logo=X_INIT, y_logo=Y_INIT, FSM in IDLE, no frame_done pulse.
REQ-044 Saturation (macro on): 300 reflections -> bounce_cnt=255 and holds at 255.

Source files
------------

// File: rtl/logo_mover.sv
// Bouncing-logo position engine: once per vblank rising edge it steps the logo
// along X, then along Y, and reflects at the screen edges. Optional reflection counter: LOGO_BOUNCE_COUNT_EN.
module logo_mover #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int WIDTH_LOGO  = 80,
    parameter int HEIGHT_LOGO = 96,
    parameter int STEP        = 1,
    parameter int X_INIT      = 0,
    parameter int Y_INIT      = 0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic       vblank,
    output logic [9:0] x_logo,
    output logic [9:0] y_logo,
    output logic       dir_x,
    output logic       dir_y,
    output logic       frame_done,
    output logic       bounce,
    output logic [7:0] bounce_cnt
);

    localparam logic [10:0] X_MAX  = 11'(H_RES - WIDTH_LOGO);
    localparam logic [10:0] Y_MAX  = 11'(V_RES - HEIGHT_LOGO);
    localparam logic [10:0] STEP_W = 11'(STEP);

    typedef enum logic [2:0] {IDLE, WAIT, STEP_X, STEP_Y, DONE} state_t;

    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
        logic       refl;
    } step_t;

    state_t state, state_nxt;
    logic   vblank_q;
    logic   vblank_rise;
    logic   refl_x;
    step_t  x_step, y_step;

    // One axis move; 11-bit compares so neither limit can be overshot or wrapped.
    function automatic step_t axis_step(input logic [9:0] pos, input logic dir,
                                        input logic [10:0] lim);
        step_t      r;
        logic [10:0] ext;
        ext    = {1'b0, pos};
        r.pos  = pos;
        r.dir  = dir;
        r.refl = 1'b0;
        if (dir) begin
            if (ext + STEP_W >= lim) begin
                r.pos  = lim[9:0];
                r.dir  = 1'b0;
                r.refl = 1'b1;
            end else begin
                r.pos = pos + STEP_W[9:0];
            end
        end else begin
            if (ext <= STEP_W) begin
                r.pos  = '0;
                r.dir  = 1'b1;
                r.refl = 1'b1;
            end else begin
                r.pos = pos - STEP_W[9:0];
            end
        end
        return r;
    endfunction

    assign vblank_rise = vblank && !vblank_q;
    assign x_step      = axis_step(x_logo, dir_x, X_MAX);
    assign y_step      = axis_step(y_logo, dir_y, Y_MAX);

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE:    if (en) state_nxt = WAIT;
            WAIT:    if (!en) state_nxt = IDLE;
                     else if (vblank_rise) state_nxt = STEP_X;
            STEP_X:  state_nxt = STEP_Y;
            STEP_Y:  state_nxt = DONE;
            DONE:    state_nxt = en ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            vblank_q   <= 1'b0;
            x_logo     <= 10'(X_INIT);
            y_logo     <= 10'(Y_INIT);
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            refl_x     <= 1'b0;
            frame_done <= 1'b0;
            bounce     <= 1'b0;
        end else begin
            state      <= state_nxt;
            vblank_q   <= vblank;
            frame_done <= (state == STEP_Y);
            bounce     <= (state == STEP_Y) && (refl_x || y_step.refl);
            if (state == STEP_X) begin
                x_logo <= x_step.pos;
                dir_x  <= x_step.dir;
                refl_x <= x_step.refl;
            end
            if (state == STEP_Y) begin
                y_logo <= y_step.pos;
                dir_y  <= y_step.dir;
            end
        end
    end

`ifdef LOGO_BOUNCE_COUNT_EN
    logic [8:0] cnt_sum;

    // Both axes are known in STEP_Y, so a corner hit adds 2 in one go.
    assign cnt_sum = {1'b0, bounce_cnt} + {7'd0, refl_x} + {7'd0, y_step.refl};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bounce_cnt <= '0;
        end else if (state == STEP_Y) begin
            bounce_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        end
    end
`else
    assign bounce_cnt = '0;
`endif

endmodule

// File: tb/tb_logo_mover.sv
// Directed bench for logo_mover: four instances with different geometries share
// one stimulus stream; table-driven frames plus hand-written corner sequences.
module tb_logo_mover;

`ifdef LOGO_BOUNCE_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr, en, vblank;

    logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y, d_x, d_y;
    logic       a_dx, a_dy, a_fd, a_bn;
    logic       b_dx, b_dy, b_fd, b_bn;
    logic       c_dx, c_dy, c_fd, c_bn;
    logic       d_dx, d_dy, d_fd, d_bn;
    logic [7:0] a_cnt, b_cnt, c_cnt, d_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Defaults: X_MAX=560, Y_MAX=384.
    logo_mover u_a (.clk(clk), .clr(clr), .en(en), .vblank(vblank), .x_logo(a_x), .y_logo(a_y),
                    .dir_x(a_dx), .dir_y(a_dy), .frame_done(a_fd), .bounce(a_bn), .bounce_cnt(a_cnt));
    // One pixel short of the right edge.
    logo_mover #(.X_INIT(559)) u_b (.clk(clk), .clr(clr), .en(en), .vblank(vblank), .x_logo(b_x),
                    .y_logo(b_y), .dir_x(b_dx), .dir_y(b_dy), .frame_done(b_fd), .bounce(b_bn),
                    .bounce_cnt(b_cnt));
    // 80x80 range, STEP=4, starting in the far corner.
    logo_mover #(.H_RES(100), .V_RES(100), .WIDTH_LOGO(20), .HEIGHT_LOGO(20), .STEP(4),
                 .X_INIT(80), .Y_INIT(80)) u_c (.clk(clk), .clr(clr), .en(en), .vblank(vblank),
                    .x_logo(c_x), .y_logo(c_y), .dir_x(c_dx), .dir_y(c_dy), .frame_done(c_fd),
                    .bounce(c_bn), .bounce_cnt(c_cnt));
    // Zero range: every update is a corner hit (two reflections).
    logo_mover #(.H_RES(80), .V_RES(96)) u_d (.clk(clk), .clr(clr), .en(en), .vblank(vblank),
                    .x_logo(d_x), .y_logo(d_y), .dir_x(d_dx), .dir_y(d_dy), .frame_done(d_fd),
                    .bounce(d_bn), .bounce_cnt(d_cnt));

    typedef struct {
        logic en;
        logic fd;
        int   ax;
        int   bx;
        int   bdx;
        int   bbn;
        int   cx;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected)
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        else
            passed++;
    endtask

    // Raise vblank and stop at the sample point of cycle 3 (DONE).
    task automatic run_frame(input logic en_v);
        @(negedge clk) en = en_v;
        @(negedge clk) vblank = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic end_frame();
        @(negedge clk) vblank = 1'b0;
        @(negedge clk);
    endtask

    task automatic count_fd(input int cycles, output int seen);
        seen = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (a_fd) seen++;
        end
    endtask

    int fd_seen;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 2, 559, 0, 0, 76};
        vecs[1] = '{1'b1, 1'b1, 3, 558, 0, 0, 72};
        for (int i = 2; i < 7; i++) vecs[i] = '{1'b0, 1'b0, 3, 558, 0, 0, 72};
        vecs[7] = '{1'b1, 1'b1, 4, 557, 0, 0, 68};

        // Reset state, with vblank toggling while clr is held.
        clr = 1'b0; en = 1'b1; vblank = 1'b0;
        repeat (2) @(negedge clk);
        vblank = 1'b1;
        @(negedge clk) vblank = 1'b0;
        #1;
        check("rst_x", a_x, 0);
        check("rst_y", a_y, 0);
        check("rst_dir_x", a_dx, 1);
        check("rst_dir_y", a_dy, 1);
        check("rst_frame_done", a_fd, 0);
        check("rst_bounce", a_bn, 0);
        check("rst_cnt", a_cnt, 0);
        check("rst_b_x", b_x, 559);
        check("rst_c_y", c_y, 80);

        // First update: latency and first reflections.
        @(negedge clk) clr = 1'b1;
        repeat (2) @(negedge clk);
        vblank = 1'b1;
        @(posedge clk); #1;
        check("lat_c1_x", a_x, 0);
        @(posedge clk); #1;
        check("lat_c2_x", a_x, 1);
        check("lat_c2_y", a_y, 0);
        check("lat_c2_fd", a_fd, 0);
        @(posedge clk); #1;
        check("lat_c3_y", a_y, 1);
        check("lat_c3_fd", a_fd, 1);
        check("lat_c3_bounce", a_bn, 0);
        check("redge_x", b_x, 560);
        check("redge_dir_x", b_dx, 0);
        check("redge_bounce", b_bn, 1);
        check("redge_cnt", b_cnt, CNT_ON ? 1 : 0);
        check("cmax_x", c_x, 80);
        check("cmax_dirs", {c_dx, c_dy}, 0);
        check("cmax_bounce", c_bn, 1);
        check("cmax_cnt", c_cnt, CNT_ON ? 2 : 0);
        @(posedge clk); #1;
        check("lat_c4_fd", a_fd, 0);
        check("redge_bounce_end", b_bn, 0);
        end_frame();

        // Table frames: updates 2..4 with five disabled frames in between.
        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].en);
            check($sformatf("v%0d_fd", i), a_fd, vecs[i].fd);
            check($sformatf("v%0d_ax", i), a_x, vecs[i].ax);
            check($sformatf("v%0d_ay", i), a_y, vecs[i].ax);
            check($sformatf("v%0d_bx", i), b_x, vecs[i].bx);
            check($sformatf("v%0d_bdx", i), b_dx, vecs[i].bdx);
            check($sformatf("v%0d_bbn", i), b_bn, vecs[i].bbn);
            check($sformatf("v%0d_cx", i), c_x, vecs[i].cx);
            end_frame();
        end

        // Stale edge: en rises while vblank already high.
        @(negedge clk) en = 1'b0;
        @(negedge clk) vblank = 1'b1;
        repeat (2) @(negedge clk);
        en = 1'b1;
        count_fd(6, fd_seen);
        check("stale_fd_count", fd_seen, 0);
        check("stale_x", a_x, 4);
        @(negedge clk) vblank = 1'b0;
        run_frame(1'b1);
        check("fresh_x", a_x, 5);
        check("fresh_fd", a_fd, 1);
        end_frame();

        // Updates 6..20 take u_c down to 4, then update 21 is a corner hit at 0.
        for (int i = 0; i < 15; i++) begin
            run_frame(1'b1);
            end_frame();
        end
        check("cmin_pre_x", c_x, 4);
        check("cmin_pre_dx", c_dx, 0);
        run_frame(1'b1);
        check("cmin_x", c_x, 0);
        check("cmin_y", c_y, 0);
        check("cmin_dirs", {c_dx, c_dy}, 2'b11);
        check("cmin_bounce", c_bn, 1);
        check("cmin_cnt", c_cnt, CNT_ON ? 4 : 0);
        check("d_cnt_21", d_cnt, CNT_ON ? 42 : 0);
        @(posedge clk); #1;
        check("cmin_bounce_end", c_bn, 0);
        end_frame();

        // Saturation on u_d: two reflections per update.
        for (int i = 0; i < 106; i++) begin
            run_frame(1'b1);
            end_frame();
        end
        check("sat_254", d_cnt, CNT_ON ? 254 : 0);
        run_frame(1'b1);
        check("sat_255", d_cnt, CNT_ON ? 255 : 0);
        check("sat_bounce", d_bn, 1);
        end_frame();
        for (int i = 0; i < 24; i++) begin
            run_frame(1'b1);
            end_frame();
        end
        check("sat_hold", d_cnt, CNT_ON ? 255 : 0);
        check("a_x_152", a_x, 152);

        // Reset during STEP_Y discards the half-done update.
        @(negedge clk) vblank = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_partial_x", a_x, 153);
        clr = 1'b0;
        #1;
        check("mid_rst_x", a_x, 0);
        check("mid_rst_y", a_y, 0);
        check("mid_rst_b_x", b_x, 559);
        count_fd(3, fd_seen);
        check("mid_rst_fd", fd_seen, 0);
        @(negedge clk) clr = 1'b1;
        count_fd(6, fd_seen);
        check("post_rst_no_update", fd_seen, 0);
        check("post_rst_x", a_x, 0);
        @(negedge clk) vblank = 1'b0;
        run_frame(1'b1);
        check("post_rst_first_x", a_x, 1);
        check("post_rst_first_y", a_y, 1);
        check("post_rst_first_fd", a_fd, 1);
        end_frame();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
